// File: rtl/wam_round_scheduler.sv
// wam_round_scheduler: Whac-A-Mole round sequencer.
// Chooses when and where a mole lights, resolves hits, misses and wrong presses,
// keeps score and shrinks on/gap times as the level rises.
// Optional build macro: WAM_STREAK_BONUS_EN (every 4th consecutive hit scores 2).
module wam_round_scheduler #(
   parameter int            TW             = 28,
   parameter logic [TW-1:0] ON_BASE        = TW'(50000000),
   parameter logic [TW-1:0] BTWN_BASE      = TW'(25000000),
   parameter logic [TW-1:0] STEP           = TW'(5000000),
   parameter logic [TW-1:0] MIN_TIME       = TW'(2),
   parameter int            HITS_PER_LEVEL = 4,
   parameter int            MAX_LEVEL      = 7,
   parameter int            MAX_MISSES     = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [3:0]    rand_sel,
   input  logic [8:0]    buttons,
   output logic [8:0]    lights,
   output logic [TW-1:0] light_on,
   output logic [TW-1:0] light_between,
   output logic [7:0]    score,
   output logic [1:0]    misses,
   output logic [2:0]    level,
   output logic          game_over
);

   localparam int HW = $clog2(HITS_PER_LEVEL + 1);

   typedef enum logic [2:0] {IDLE, GAP, LIT, RESOLVE, OVER} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [HW-1:0] hits_in_level;
   logic [8:0]    btn_q;
   logic          got_hit;     // outcome of the LIT phase, consumed in RESOLVE

   logic [8:0]    press;
   logic [1:0]    inc;
   logic [8:0]    sum9;
   logic [7:0]    score_n;
   logic [1:0]    misses_n;
   logic [HW-1:0] hits_n;
   logic [TW-1:0] on_dec;
   logic [TW-1:0] btwn_dec;

`ifdef WAM_STREAK_BONUS_EN
   logic [1:0]    streak;
`endif

   // Shrink a time by STEP, floored at MIN_TIME; compare first so nothing wraps.
   function automatic logic [TW-1:0] shrink(input logic [TW-1:0] t);
      logic [TW-1:0] r;
      if (t <= STEP)                r = MIN_TIME;
      else if ((t - STEP) < MIN_TIME) r = MIN_TIME;
      else                          r = t - STEP;
      return r;
   endfunction

   // Press edges and the candidate RESOLVE updates.
   always_comb begin
      press = buttons & ~btn_q;
      inc   = 2'd1;
`ifdef WAM_STREAK_BONUS_EN
      if (streak == 2'd3) inc = 2'd2;
`endif
      sum9     = {1'b0, score} + {7'd0, inc};
      score_n  = score;
      if (got_hit) score_n = (sum9 > 9'd255) ? 8'd255 : sum9[7:0];
      misses_n = got_hit ? misses : misses + 2'd1;
      hits_n   = got_hit ? hits_in_level + HW'(1) : hits_in_level;
      on_dec   = shrink(light_on);
      btwn_dec = shrink(light_between);
   end

   // Round sequencer: all outputs are registered here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         timer         <= '0;
         hits_in_level <= '0;
         btn_q         <= '0;
         got_hit       <= 1'b0;
         lights        <= '0;
         light_on      <= ON_BASE;
         light_between <= BTWN_BASE;
         score         <= '0;
         misses        <= '0;
         level         <= '0;
         game_over     <= 1'b0;
`ifdef WAM_STREAK_BONUS_EN
         streak        <= '0;
`endif
      end else begin
         btn_q <= buttons;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= GAP;
                  timer <= light_between - TW'(1);
               end
            end
            GAP: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else if (rand_sel <= 4'd8) begin
                  state  <= LIT;
                  lights <= 9'd1 << rand_sel;
                  timer  <= light_on - TW'(1);
               end
            end
            LIT: begin
               // A correct press wins over a simultaneous wrong one.
               if ((press != '0) || (timer == '0)) begin
                  got_hit <= |(press & lights);
                  lights  <= '0;
                  state   <= RESOLVE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            RESOLVE: begin
               score  <= score_n;
               misses <= misses_n;
`ifdef WAM_STREAK_BONUS_EN
               if (got_hit) streak <= (streak == 2'd3) ? 2'd0 : streak + 2'd1;
               else         streak <= 2'd0;
`endif
               if (misses_n == 2'(MAX_MISSES)) begin
                  state         <= OVER;
                  game_over     <= 1'b1;
                  hits_in_level <= hits_n;
               end else begin
                  state <= GAP;
                  if ((hits_n == HW'(HITS_PER_LEVEL)) && (level < 3'(MAX_LEVEL))) begin
                     level         <= level + 3'd1;
                     hits_in_level <= '0;
                     light_on      <= on_dec;
                     light_between <= btwn_dec;
                     timer         <= btwn_dec - TW'(1);
                  end else begin
                     hits_in_level <= (level == 3'(MAX_LEVEL)) ? '0 : hits_n;
                     timer         <= light_between - TW'(1);
                  end
               end
            end
            OVER: begin
               lights    <= '0;
               game_over <= 1'b1;
               if (start) begin
                  score         <= '0;
                  misses        <= '0;
                  level         <= '0;
                  hits_in_level <= '0;
                  light_on      <= ON_BASE;
                  light_between <= BTWN_BASE;
                  game_over     <= 1'b0;
                  timer         <= BTWN_BASE - TW'(1);
                  state         <= GAP;
`ifdef WAM_STREAK_BONUS_EN
                  streak        <= '0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wam_round_scheduler.sv
// Bench for wam_round_scheduler: directed round table plus randomized rounds
// checked against a round-level score/level model.
module tb_wam_round_scheduler;

   localparam int ON_B = 8, BT_B = 4, STP = 2, MINT = 2, HPL = 2, MAXL = 7, MAXM = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  rand_sel = '0;
   logic [8:0]  buttons = '0;
   logic [8:0]  lights;
   logic [27:0] light_on, light_between;
   logic [7:0]  score;
   logic [1:0]  misses;
   logic [2:0]  level;
   logic        game_over;

   int tests = 0;
   int fails = 0;

   // round-level model
   int m_score, m_miss, m_level, m_hits, m_lon, m_lb, m_streak;
   bit m_over;

   wam_round_scheduler #(
      .TW(28), .ON_BASE(28'd8), .BTWN_BASE(28'd4), .STEP(28'd2), .MIN_TIME(28'd2),
      .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAXL), .MAX_MISSES(MAXM)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rand_sel(rand_sel), .buttons(buttons),
      .lights(lights), .light_on(light_on), .light_between(light_between),
      .score(score), .misses(misses), .level(level), .game_over(game_over)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // kind: 0 timeout, 1 hit, 2 wrong press, 3 hit+wrong, 4 hit with button held afterwards
   typedef struct {
      int pos, kind, k, ninv, wpos;
      int score, miss, level, lon, lb;
      bit over;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int shrink(input int t);
      return (t - STP < MINT) ? MINT : t - STP;
   endfunction

   task automatic model_reset();
      m_score = 0; m_miss = 0; m_level = 0; m_hits = 0; m_streak = 0;
      m_lon = ON_B; m_lb = BT_B; m_over = 0;
   endtask

   task automatic model_round(input bit hit);
      int inc;
      if (hit) begin
         inc = 1;
`ifdef WAM_STREAK_BONUS_EN
         if (m_streak == 3) begin inc = 2; m_streak = 0; end
         else m_streak++;
`endif
         m_score = (m_score + inc > 255) ? 255 : m_score + inc;
         m_hits++;
      end else begin
         m_miss++;
         m_streak = 0;
      end
      if (m_miss == MAXM) m_over = 1;
      else if (m_hits == HPL && m_level < MAXL) begin
         m_level++; m_hits = 0;
         m_lon = shrink(m_lon); m_lb = shrink(m_lb);
      end else if (m_level == MAXL) m_hits = 0;
   endtask

   // Entered at the first negedge of a GAP; returns at the negedge after RESOLVE.
   task automatic run_round(input int pos, input int kind, input int k, input int ninv, input int wpos);
      int gl, lit_n;
      logic [8:0] onehot;
      gl = m_lb + ninv;
      onehot = 9'd1 << pos;
      for (int i = 0; i < gl; i++) begin
         chk("gap_lights", lights, 0);
         rand_sel = (i == gl - 1) ? 4'(pos) : 4'(9 + $urandom_range(0, 6));
         @(negedge clk);
      end
      lit_n = (kind == 0) ? m_lon : k + 1;
      for (int j = 0; j < lit_n; j++) begin
         chk("lit_lights", lights, onehot);
         if (kind != 0 && j == k) begin
            case (kind)
               2:       buttons = 9'd1 << wpos;
               3:       buttons = onehot | (9'd1 << wpos);
               default: buttons = onehot;
            endcase
         end
         @(negedge clk);
      end
      chk("resolve_lights", lights, 0);
      chk("resolve_go", game_over, 0);
      if (kind != 4) buttons = '0;
      model_round(kind == 1 || kind == 3 || kind == 4);
      @(negedge clk);
   endtask

   task automatic chk_outputs(input string tag, input int s, input int mi, input int lv,
                              input int lon, input int lb, input bit ov);
      chk({tag, "_score"}, score, s);
      chk({tag, "_misses"}, misses, mi);
      chk({tag, "_level"}, level, lv);
      chk({tag, "_light_on"}, light_on, lon);
      chk({tag, "_light_between"}, light_between, lb);
      chk({tag, "_game_over"}, game_over, ov);
   endtask

   task automatic restart();
      chk("over_lights", lights, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_reset();
      chk_outputs("restart", 0, 0, 0, ON_B, BT_B, 0);
   endtask

   initial begin
      //            pos kind k ninv wpos  score miss lvl lon lb over
      tbl[0] = '{5, 0, 0, 0, 0,  0, 1, 0, 8, 4, 0};
      tbl[1] = '{5, 4, 2, 0, 0,  1, 1, 0, 8, 4, 0};
      tbl[2] = '{5, 0, 0, 0, 0,  1, 2, 0, 8, 4, 0};
      tbl[3] = '{5, 3, 0, 0, 2,  2, 2, 1, 6, 2, 0};
      tbl[4] = '{0, 1, 0, 0, 0,  3, 2, 1, 6, 2, 0};
      tbl[5] = '{8, 1, 5, 0, 0,  4, 2, 2, 4, 2, 0};
      tbl[6] = '{3, 1, 1, 1, 0,  5, 2, 2, 4, 2, 0};
      tbl[7] = '{3, 2, 0, 0, 2,  5, 3, 2, 4, 2, 1};

      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_lights", lights, 0);
      chk_outputs("reset", 0, 0, 0, ON_B, BT_B, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_lights", lights, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // directed rounds
      for (int v = 0; v < 8; v++) begin
         run_round(tbl[v].pos, tbl[v].kind, tbl[v].k, tbl[v].ninv, tbl[v].wpos);
         chk_outputs($sformatf("tbl%0d", v), tbl[v].score, tbl[v].miss, tbl[v].level,
                     tbl[v].lon, tbl[v].lb, tbl[v].over);
      end
      restart();

      // randomized rounds against the model
      for (int r = 0; r < 250; r++) begin
         int pos, kind, k, ninv, wpos, sel;
         pos  = $urandom_range(0, 8);
         sel  = $urandom_range(0, 7);
         kind = (sel <= 4) ? 1 : (sel == 5) ? 3 : (sel == 6) ? 2 : 0;
         k    = $urandom_range(0, m_lon - 1);
         ninv = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         wpos = (pos + 1 + $urandom_range(0, 7)) % 9;
         run_round(pos, kind, k, ninv, wpos);
         chk_outputs($sformatf("rnd%0d", r), m_score, m_miss, m_level, m_lon, m_lb, m_over);
         if (m_over) restart();
      end

      // reset in the middle of a lit mole
      rand_sel = 4'd4;
      for (int i = 0; i < m_lb; i++) @(negedge clk);
      chk("pre_reset_lights", lights, 9'h010);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_lights", lights, 0);
      chk_outputs("midreset", 0, 0, 0, ON_B, BT_B, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", lights, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_reset();
      run_round(4, 1, 0, 0, 0);
      chk_outputs("after_reset", m_score, m_miss, m_level, m_lon, m_lb, m_over);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
